store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
Posted-write buffer between the core's MEM-stage data port and the registered data RAM.
- Stores from the core are aligned to byte lanes and queued in a small FIFO. They drain to RAM in cycles when no load needs the port.
- Loads bypass the queue straight to RAM. A load whose word address matches a queued store stalls the core until that store has drained (RAW-safe, no forwarding).
- A fence request stalls the core until the queue is empty.

Parameters:
DATA_SIZE, 32, data word width; must be 32.
ADDR_SIZE, 10, RAM word-address width.
DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
CLK  input  1  clock; all state updates on rising edge.
RESET  input  1  synchronous, active-high reset.
core_mem_write  input  1  MEM-stage store request.
core_mem_read  input  1  MEM-stage load request.
core_daddr  input  ADDR_SIZE  word address.
core_byte_off  input  2  byte offset within word (address bits 1:0).
core_funct3  input  3  store width: 000 SB, 001 SH, 010 SW.
core_wdata  input  DATA_SIZE  store data, right-aligned.
fence_req  input  1  drain-all request, level-held by core.
core_rdata  output  DATA_SIZE  load data; equals ram_rdata (pass-through).
stall  output  1  core must hold MEM stage and below.
ram_addr  output  ADDR_SIZE  RAM word address.
ram_wdata  output  DATA_SIZE  lane-aligned write data.
ram_be  output  DATA_SIZE/8  byte enables.
ram_we  output  1  RAM write strobe.
ram_re  output  1  RAM read strobe.
occupancy  output  $clog2(DEPTH)+1  queued-entry count.

Behaviour:
- Reset (RESET=1 at edge): wr_ptr, rd_ptr and count cleared; occupancy=0. All queued stores are discarded, including mid-drain ones; the core is reset with the buffer.
- Entry contents: {addr, be, wdata}.
- Alignment (combinational, at enqueue):
  - SB: be=0001<<off; data=byte replicated to all 4 lanes.
  - SH: be=0011<<{off[1],1'b0}; data=half replicated to both halves. off[0] is ignored.
  - SW and every other funct3: be=1111; data unchanged. off is ignored.
- Load hit: core_mem_read=1 and any valid entry has addr==core_daddr.
- stall (combinational) = load hit | (core_mem_write & full) | (fence_req & count!=0).
- RAM port arbitration, one access per cycle:
  - core_mem_read & !hit: ram_re=1, ram_addr=core_daddr, ram_we=0. Drain waits.
  - Otherwise, if count!=0: ram_we=1 with the head entry; rd_ptr advances.
  - Otherwise: ram_we=ram_re=0, ram_be=0.
- Enqueue: core_mem_write & !full at a clock edge writes the entry at wr_ptr and advances wr_ptr.
- Full store: when full, the store is not written. stall holds the core; the same request is re-presented and accepted on the first edge where full=0. Enqueue does not consider a same-cycle dequeue (no combinational full-to-drain path).
- Simultaneous enqueue and dequeue: count unchanged; both pointers advance.
- Pointers wrap modulo DEPTH; full = count==DEPTH.
- core_mem_read and core_mem_write both high: the store is processed, the load is ignored (illegal from the core).
- Load-hit resolution: the drain runs during the stall. stall falls in the cycle after the last matching entry retires, and the load then issues to RAM.
- Read latency: set by the RAM; core_rdata = ram_rdata with no added latency.
- Ordering: drain is strictly FIFO, so RAM write order equals program store order.

Decomposition:
- Package sb_pkg holds:
  - funct3 constants SB_F3, SH_F3, SW_F3;
  - typedef sb_entry_t {addr, be, wdata};
  - function sb_align(funct3, off, wdata) returning {be, data}.
- One sub-module, sb_fifo: parameterised DEPTH circular queue with push, pop, head, count, full, empty, and a parallel address-compare output (per-entry valid & addr match).
- The top level contains arbitration, stall logic and alignment.

Test Plan:
- SW addr 5 data 0xDEADBEEF, no loads -> next cycle ram_we=1, ram_addr=5, ram_be=1111, ram_wdata=0xDEADBEEF; occupancy 1 then 0.
- SB off=2 data 0x000000AB at addr 3, then SH off=2 data 0x1234 at addr 3 -> drains in order: be=0100 with wdata=0xABABABAB, then be=1100 with wdata=0x12341234.
- 5 back-to-back SW with DEPTH=4 and continuous loads to non-matching addresses -> occupancy reaches 4, stall=1 on the 5th store. Drain is blocked while loads hold the port; the 5th store is accepted after the loads stop and one entry retires.
- SW to addr 7, then immediately LW addr 7 -> stall=1 until the addr-7 write retires; ram_re for addr 7 occurs strictly after that ram_we.
- 3 stores queued, fence_req=1 -> stall stays 1 for 3 cycles; stall=0 in the cycle occupancy reads 0.
- 3 stores queued, RESET=1 for one cycle -> occupancy=0, no further ram_we, stall=0.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared types and helpers for the store buffer: funct3 codes, queue entry
// layout and store lane alignment.
package sb_pkg;

    localparam int unsigned SB_DATA_W = 32;
    localparam int unsigned SB_ADDR_W = 10;
    localparam int unsigned SB_BE_W   = SB_DATA_W / 8;

    localparam logic [2:0] SB_F3 = 3'b000;
    localparam logic [2:0] SH_F3 = 3'b001;
    localparam logic [2:0] SW_F3 = 3'b010;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_BE_W-1:0]   be;
        logic [SB_DATA_W-1:0] wdata;
    } sb_entry_t;

    typedef struct packed {
        logic [SB_BE_W-1:0]   be;
        logic [SB_DATA_W-1:0] data;
    } sb_align_t;

    // Byte/half data is replicated so the RAM only needs the byte enables.
    function automatic sb_align_t sb_align(input logic [2:0]           funct3,
                                           input logic [1:0]           off,
                                           input logic [SB_DATA_W-1:0] wdata);
        sb_align_t r;
        case (funct3)
            SB_F3: begin
                r.be   = SB_BE_W'(4'b0001 << off);
                r.data = {4{wdata[7:0]}};
            end
            SH_F3: begin
                r.be   = SB_BE_W'(4'b0011 << {off[1], 1'b0});
                r.data = {2{wdata[15:0]}};
            end
            SW_F3: begin
                r.be   = 4'b1111;
                r.data = wdata;
            end
            default: begin
                r.be   = 4'b1111;
                r.data = wdata;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Core MEM-stage and data-RAM port bundle seen by the store buffer.
interface store_buffer_if #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned ADDR_SIZE = 10,
    parameter int unsigned DEPTH     = 4
);
    localparam int unsigned BE_W  = DATA_SIZE / 8;
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    logic                 core_mem_write;
    logic                 core_mem_read;
    logic [ADDR_SIZE-1:0] core_daddr;
    logic [1:0]           core_byte_off;
    logic [2:0]           core_funct3;
    logic [DATA_SIZE-1:0] core_wdata;
    logic                 fence_req;
    logic [DATA_SIZE-1:0] core_rdata;
    logic                 stall;
    logic [ADDR_SIZE-1:0] ram_addr;
    logic [DATA_SIZE-1:0] ram_wdata;
    logic [BE_W-1:0]      ram_be;
    logic                 ram_we;
    logic                 ram_re;
    logic [DATA_SIZE-1:0] ram_rdata;
    logic [OCC_W-1:0]     occupancy;

    modport master (
        output core_mem_write, core_mem_read, core_daddr, core_byte_off,
               core_funct3, core_wdata, fence_req, ram_rdata,
        input  core_rdata, stall, ram_addr, ram_wdata, ram_be, ram_we,
               ram_re, occupancy
    );

    modport slave (
        input  core_mem_write, core_mem_read, core_daddr, core_byte_off,
               core_funct3, core_wdata, fence_req, ram_rdata,
        output core_rdata, stall, ram_addr, ram_wdata, ram_be, ram_we,
               ram_re, occupancy
    );

endinterface

// File: rtl/sb_fifo.sv
// Circular store queue with per-entry address compare for load hazard detection.
module sb_fifo
    import sb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  sb_entry_t              push_data_i,
    input  logic                   pop_i,
    input  logic [SB_ADDR_W-1:0]   cmp_addr_i,
    output sb_entry_t              head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [DEPTH-1:0]       match_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    sb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    // Entry g is live when its distance from the head is below the count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
        logic [PTR_W-1:0] offs;
        assign offs       = PTR_W'(g) - rd_ptr_q;
        assign match_o[g] = ({1'b0, offs} < count_q) && (mem_q[g].addr == cmp_addr_i);
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the core data port and the data RAM: loads take
// the port first, queued stores drain in idle cycles, RAW hits and fences stall.
module store_buffer
    import sb_pkg::*;
#(
    parameter int unsigned DATA_SIZE = SB_DATA_W,
    parameter int unsigned ADDR_SIZE = SB_ADDR_W,
    parameter int unsigned DEPTH     = 4
) (
    input  logic           CLK,
    input  logic           RESET,
    store_buffer_if.slave  bus
);
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;
    localparam int unsigned BE_W  = DATA_SIZE / 8;

    sb_align_t        aligned;
    sb_entry_t        enq_entry;
    sb_entry_t        head;
    logic [OCC_W-1:0] count;
    logic             full, empty;
    logic [DEPTH-1:0] match;
    logic             load_chk, hit, load_port, drain;

    assign aligned = sb_align(bus.core_funct3, bus.core_byte_off, SB_DATA_W'(bus.core_wdata));

    always_comb begin
        enq_entry       = '0;
        enq_entry.addr  = SB_ADDR_W'(bus.core_daddr);
        enq_entry.be    = aligned.be;
        enq_entry.wdata = aligned.data;
    end

    sb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (CLK),
        .rst         (RESET),
        .push_i      (bus.core_mem_write),
        .push_data_i (enq_entry),
        .pop_i       (drain),
        .cmp_addr_i  (SB_ADDR_W'(bus.core_daddr)),
        .head_o      (head),
        .count_o     (count),
        .full_o      (full),
        .empty_o     (empty),
        .match_o     (match)
    );

    // A load paired with a store is never hazard-checked; the store wins.
    assign load_chk  = bus.core_mem_read & ~bus.core_mem_write;
    assign hit       = load_chk & (|match);
    assign load_port = bus.core_mem_read & ~hit;
    assign drain     = ~load_port & ~empty;

    assign bus.stall      = hit | (bus.core_mem_write & full) | (bus.fence_req & ~empty);
    assign bus.occupancy  = count;
    assign bus.core_rdata = bus.ram_rdata;

    always_comb begin
        bus.ram_we    = 1'b0;
        bus.ram_re    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        bus.ram_be    = '0;
        if (load_port) begin
            bus.ram_re   = 1'b1;
            bus.ram_addr = bus.core_daddr;
        end else if (drain) begin
            bus.ram_we    = 1'b1;
            bus.ram_addr  = ADDR_SIZE'(head.addr);
            bus.ram_be    = BE_W'(head.be);
            bus.ram_wdata = DATA_SIZE'(head.wdata);
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected RAM writes are queued as stores
// are issued and checked in order by a monitor on every ram_we cycle.
module tb_store_buffer;
    import sb_pkg::*;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [3:0]    be;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    wr_t  exp_q[$];

    always #5 clk = ~clk;

    store_buffer_if #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .DEPTH(DEPTH)) bus ();

    store_buffer #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .DEPTH(DEPTH)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic wr, input logic rd, input logic [2:0] f3,
                         input logic [1:0] off, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data);
        bus.core_mem_write = wr;
        bus.core_mem_read  = rd;
        bus.core_funct3    = f3;
        bus.core_byte_off  = off;
        bus.core_daddr     = addr;
        bus.core_wdata     = data;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, SW_F3, 2'd0, '0, '0);
        bus.fence_req = 1'b0;
    endtask

    task automatic expect_wr(input logic [AW-1:0] addr, input logic [3:0] be, input logic [DW-1:0] data);
        wr_t e;
        e.addr = addr;
        e.be   = be;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic drain_wait(input string name);
        int n = 0;
        while (bus.occupancy != 0 && n < 12) begin
            tick();
            n++;
        end
        @(negedge clk);
        chk(name, 32'(bus.occupancy), 32'd0);
    endtask

    // Every RAM write must match the oldest outstanding expected store.
    always @(negedge clk) begin
        if (!rst && bus.ram_we) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL ram_write: got unexpected write addr=%0d be=%b data=0x%0h at %0t",
                         bus.ram_addr, bus.ram_be, bus.ram_wdata, $time);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (bus.ram_addr !== e.addr || bus.ram_be !== e.be || bus.ram_wdata !== e.data) begin
                    fails++;
                    $display("FAIL ram_write: got addr=%0d be=%b data=0x%0h expected addr=%0d be=%b data=0x%0h at %0t",
                             bus.ram_addr, bus.ram_be, bus.ram_wdata, e.addr, e.be, e.data, $time);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        rst           = 1'b1;
        bus.ram_rdata = '0;
        idle();
        tick();
        tick();
        @(negedge clk);
        chk("reset_occ", 32'(bus.occupancy), 32'd0);
        chk("reset_stall", 32'(bus.stall), 32'd0);
        chk("reset_we", 32'(bus.ram_we), 32'd0);
        tick();
        rst = 1'b0;

        // Single word store drains the following cycle.
        drive(1'b1, 1'b0, SW_F3, 2'd0, 10'd5, 32'hDEADBEEF);
        expect_wr(10'd5, 4'b1111, 32'hDEADBEEF);
        @(negedge clk);
        chk("sw_occ0", 32'(bus.occupancy), 32'd0);
        chk("sw_we0", 32'(bus.ram_we), 32'd0);
        tick();
        idle();
        @(negedge clk);
        chk("sw_occ1", 32'(bus.occupancy), 32'd1);
        chk("sw_we1", 32'(bus.ram_we), 32'd1);
        chk("sw_addr", 32'(bus.ram_addr), 32'd5);
        tick();
        @(negedge clk);
        chk("sw_occ_after", 32'(bus.occupancy), 32'd0);
        chk("sw_we_after", 32'(bus.ram_we), 32'd0);
        tick();

        // Byte then half store to the same word drain in program order.
        drive(1'b1, 1'b0, SB_F3, 2'd2, 10'd3, 32'h000000AB);
        expect_wr(10'd3, 4'b0100, 32'hABABABAB);
        tick();
        drive(1'b1, 1'b0, SH_F3, 2'd2, 10'd3, 32'h00001234);
        expect_wr(10'd3, 4'b1100, 32'h12341234);
        @(negedge clk);
        chk("sbsh_occ", 32'(bus.occupancy), 32'd1);
        tick();
        idle();
        drain_wait("sbsh_drained");
        tick();

        // Loads paired with stores hold the port, so the queue fills.
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, SW_F3, 2'd0, AW'(20 + k), 32'h1000 + k);
            expect_wr(AW'(20 + k), 4'b1111, 32'h1000 + k);
            @(negedge clk);
            if (k < 4) begin
                chk("fill_occ", 32'(bus.occupancy), 32'(k));
                chk("fill_stall", 32'(bus.stall), 32'd0);
                chk("fill_re", 32'(bus.ram_re), 32'd1);
                chk("fill_we", 32'(bus.ram_we), 32'd0);
                tick();
            end else begin
                chk("full_occ", 32'(bus.occupancy), 32'd4);
                chk("full_stall", 32'(bus.stall), 32'd1);
                chk("full_we", 32'(bus.ram_we), 32'd0);
            end
        end
        tick();
        drive(1'b1, 1'b0, SW_F3, 2'd0, 10'd24, 32'h1004);
        @(negedge clk);
        chk("full_hold_occ", 32'(bus.occupancy), 32'd4);
        chk("full_hold_stall", 32'(bus.stall), 32'd1);
        chk("full_hold_we", 32'(bus.ram_we), 32'd1);
        tick();
        @(negedge clk);
        chk("full_room_occ", 32'(bus.occupancy), 32'd3);
        chk("full_room_stall", 32'(bus.stall), 32'd0);
        tick();
        idle();
        @(negedge clk);
        chk("full_accept_occ", 32'(bus.occupancy), 32'd3);
        drain_wait("full_drained");
        tick();

        // Load to a queued address waits for that store to retire.
        drive(1'b1, 1'b0, SW_F3, 2'd0, 10'd7, 32'h77770007);
        expect_wr(10'd7, 4'b1111, 32'h77770007);
        tick();
        drive(1'b0, 1'b1, SW_F3, 2'd0, 10'd7, 32'h0);
        bus.ram_rdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("raw_stall", 32'(bus.stall), 32'd1);
        chk("raw_we", 32'(bus.ram_we), 32'd1);
        chk("raw_re_blocked", 32'(bus.ram_re), 32'd0);
        tick();
        @(negedge clk);
        chk("raw_release", 32'(bus.stall), 32'd0);
        chk("raw_re", 32'(bus.ram_re), 32'd1);
        chk("raw_re_addr", 32'(bus.ram_addr), 32'd7);
        chk("rdata_pass", bus.core_rdata, 32'hCAFEF00D);
        tick();
        idle();

        // Fence holds the core until the queue is empty.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, SW_F3, 2'd0, AW'(40 + k), 32'h4000 + k);
            expect_wr(AW'(40 + k), 4'b1111, 32'h4000 + k);
            tick();
        end
        idle();
        bus.fence_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("fence_occ", 32'(bus.occupancy), 32'(3 - i));
            chk("fence_stall", 32'(bus.stall), (i < 3) ? 32'd1 : 32'd0);
            tick();
        end
        idle();

        // Reset discards queued stores.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, SW_F3, 2'd0, AW'(50 + k), 32'h5000 + k);
            tick();
        end
        drive(1'b0, 1'b1, SW_F3, 2'd0, 10'd60, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_pre_occ", 32'(bus.occupancy), 32'd3);
        chk("rst_pre_we", 32'(bus.ram_we), 32'd0);
        tick();
        rst = 1'b0;
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_occ", 32'(bus.occupancy), 32'd0);
            chk("rst_stall", 32'(bus.stall), 32'd0);
            chk("rst_we", 32'(bus.ram_we), 32'd0);
            tick();
        end

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
